// File: rtl/intel8254_pkg.sv
// Shared definitions for the 8254 counter slices.
// Purpose : read/write-mode encoding, bus address constants, control-word,
//           read-back and status-byte bit positions, and the mode mapping
//           used when a control word is decoded.
// Ports   : none (package).
// Macros  : none here; COUNTER_READBACK_EN is consumed by the modules.
package intel8254_pkg;

   typedef enum logic [1:0] {
      RW_LATCH   = 2'b00,
      RW_LSB     = 2'b01,
      RW_MSB     = 2'b10,
      RW_LSB_MSB = 2'b11
   } rw_t;

   localparam logic [1:0] ADDR_CTRL   = 2'b11;
   localparam logic [1:0] SC_READBACK = 2'b11;
   localparam logic [2:0] MODE_RESET  = 3'b001;

   // Control word fields
   localparam int CW_SC_MSB = 7;
   localparam int CW_SC_LSB = 6;
   localparam int CW_RW_MSB = 5;
   localparam int CW_RW_LSB = 4;
   localparam int CW_M_MSB  = 3;
   localparam int CW_M_LSB  = 1;
   localparam int CW_BCD    = 0;

   // Read-back command: these bits are active-low "do latch" flags
   localparam int RB_NCOUNT  = 5;
   localparam int RB_NSTATUS = 4;

   // Status byte layout
   localparam int ST_OUT    = 7;
   localparam int ST_NULL   = 6;
   localparam int ST_RW_MSB = 5;
   localparam int ST_RW_LSB = 4;
   localparam int ST_M_MSB  = 3;
   localparam int ST_M_LSB  = 1;
   localparam int ST_BCD    = 0;

   // Modes 6 and 7 are aliases of modes 2 and 3.
   function automatic logic [2:0] map_mode(input logic [2:0] m);
      return (m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
   endfunction

endpackage

// File: rtl/counter_access_unit_count_read_latch.sv
// count_read_latch: read side of one 8254 counter.
// Purpose : holds the count latch (and status latch when read-back exists),
//           the read byte pointer, and the byte mux feeding the CPU read.
// Ports   : clk/rst        clock, async active-high reset
//           clear          drop latches and reset pointer (reprogramming)
//           latch_cmd      snapshot current_count if no latch held
//           status_cmd     snapshot status_in if no status held (read-back)
//           status_in      status byte to capture (read-back)
//           rd_strobe      a CPU byte read of this counter is happening
//           rw             programmed read/write mode
//           current_count  live count from the counter
//           rd_data        byte the next read returns (combinational)
// Macros  : COUNTER_READBACK_EN adds the status latch.
module count_read_latch
   import intel8254_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        latch_cmd,
`ifdef COUNTER_READBACK_EN
   input  logic        status_cmd,
   input  logic [7:0]  status_in,
`endif
   input  logic        rd_strobe,
   input  logic [1:0]  rw,
   input  logic [15:0] current_count,
   output logic [7:0]  rd_data
);

   logic [15:0] latch_q, latch_d;
   logic        latched_q, latched_d;
   logic        rd_msb_q, rd_msb_d;
   logic [15:0] src;
`ifdef COUNTER_READBACK_EN
   logic [7:0]  status_q, status_d;
   logic        status_held_q, status_held_d;
`endif

   always_comb begin
      latch_d   = latch_q;
      latched_d = latched_q;
      rd_msb_d  = rd_msb_q;
      src       = latched_q ? latch_q : current_count;
      case (rw)
         RW_MSB:     rd_data = src[15:8];
         RW_LSB_MSB: rd_data = rd_msb_q ? src[15:8] : src[7:0];
         default:    rd_data = src[7:0];
      endcase
`ifdef COUNTER_READBACK_EN
      status_d      = status_q;
      status_held_d = status_held_q;
      // A held status byte is always returned before any count byte.
      if (status_held_q) rd_data = status_q;
`endif

      if (clear) begin
         latched_d = 1'b0;
         rd_msb_d  = 1'b0;
`ifdef COUNTER_READBACK_EN
         status_held_d = 1'b0;
`endif
      end else begin
         if (rd_strobe) begin
`ifdef COUNTER_READBACK_EN
            if (status_held_q) begin
               status_held_d = 1'b0;
            end else
`endif
            // The latch is released once the last byte of the rw sequence goes out.
            if (rw == RW_LSB_MSB) begin
               rd_msb_d = ~rd_msb_q;
               if (rd_msb_q) latched_d = 1'b0;
            end else begin
               latched_d = 1'b0;
            end
         end
         if (latch_cmd && !latched_q) begin
            latch_d   = current_count;
            latched_d = 1'b1;
         end
`ifdef COUNTER_READBACK_EN
         if (status_cmd && !status_held_q) begin
            status_d      = status_in;
            status_held_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q   <= '0;
         latched_q <= 1'b0;
         rd_msb_q  <= 1'b0;
`ifdef COUNTER_READBACK_EN
         status_q      <= '0;
         status_held_q <= 1'b0;
`endif
      end else begin
         latch_q   <= latch_d;
         latched_q <= latched_d;
         rd_msb_q  <= rd_msb_d;
`ifdef COUNTER_READBACK_EN
         status_q      <= status_d;
         status_held_q <= status_held_d;
`endif
      end
   end

endmodule

// File: rtl/counter_access_unit.sv
// counter_access_unit: CPU-side access stage for one 8254 counter.
// Purpose : decodes control words and count writes, assembles the 16-bit
//           initial count and issues a one-cycle load strobe; serves count
//           reads and latch commands through count_read_latch.
// Ports   : clk, rst (async active-high); wr_en, rd_en, addr, data_in,
//           data_out (registered read data); count_out, count_load, cs_out,
//           mode_out, bcd_out, null_count to the counter; current_count and
//           out_in from the counter.
// Macros  : COUNTER_READBACK_EN enables the SC=11 read-back command.
module counter_access_unit
   import intel8254_pkg::*;
#(
   parameter logic [1:0] COUNTER_ID = 2'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [15:0] count_out,
   output logic        count_load,
   output logic        cs_out,
   output logic [2:0]  mode_out,
   output logic        bcd_out,
   output logic        null_count,
   input  logic [15:0] current_count,
   input  logic        out_in
);

   logic [1:0]  rw_q, rw_d;
   logic [2:0]  mode_q, mode_d;
   logic        bcd_q, bcd_d;
   logic        cs_q, cs_d;
   logic        null_q, null_d;
   logic        load_q, load_d;
   logic        wr_msb_q, wr_msb_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  staged_q, staged_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        latch_cmd, clear_latch, rd_strobe;
   logic [7:0]  rd_data;
   logic [1:0]  cw_sc, cw_rw;

`ifdef COUNTER_READBACK_EN
   localparam int RB_SEL_BIT = int'(COUNTER_ID) + 1;
   logic        status_cmd;
   logic [7:0]  status_byte;

   always_comb begin
      status_byte                      = '0;
      status_byte[ST_OUT]              = out_in;
      status_byte[ST_NULL]             = null_q;
      status_byte[ST_RW_MSB:ST_RW_LSB] = rw_q;
      status_byte[ST_M_MSB:ST_M_LSB]   = mode_q;
      status_byte[ST_BCD]              = bcd_q;
   end
`else
   logic unused_out_in;
   assign unused_out_in = out_in;
`endif

   assign cw_sc = data_in[CW_SC_MSB:CW_SC_LSB];
   assign cw_rw = data_in[CW_RW_MSB:CW_RW_LSB];

   // A write on the same cycle wins, so the read side only sees clean reads.
   assign rd_strobe = rd_en && !wr_en && (addr == COUNTER_ID);

   always_comb begin
      rw_d        = rw_q;
      mode_d      = mode_q;
      bcd_d       = bcd_q;
      cs_d        = cs_q;
      null_d      = null_q;
      load_d      = 1'b0;
      wr_msb_d    = wr_msb_q;
      count_d     = count_q;
      staged_d    = staged_q;
      data_out_d  = data_out_q;
      latch_cmd   = 1'b0;
      clear_latch = 1'b0;
`ifdef COUNTER_READBACK_EN
      status_cmd  = 1'b0;
`endif

      if (wr_en && addr == ADDR_CTRL) begin
         if (cw_sc == COUNTER_ID) begin
            if (cw_rw == RW_LATCH) begin
               latch_cmd = 1'b1;
            end else begin
               // Programming idles the counter and abandons any half-written count.
               rw_d        = cw_rw;
               mode_d      = map_mode(data_in[CW_M_MSB:CW_M_LSB]);
               bcd_d       = data_in[CW_BCD];
               cs_d        = 1'b0;
               null_d      = 1'b1;
               wr_msb_d    = 1'b0;
               clear_latch = 1'b1;
            end
         end
`ifdef COUNTER_READBACK_EN
         else if (cw_sc == SC_READBACK && data_in[RB_SEL_BIT]) begin
            latch_cmd  = !data_in[RB_NCOUNT];
            status_cmd = !data_in[RB_NSTATUS];
         end
`endif
      end else if (wr_en && addr == COUNTER_ID) begin
         case (rw_q)
            RW_LSB: begin
               count_d = {8'h00, data_in};
               load_d  = 1'b1;
            end
            RW_MSB: begin
               count_d = {data_in, 8'h00};
               load_d  = 1'b1;
            end
            RW_LSB_MSB: begin
               wr_msb_d = ~wr_msb_q;
               if (wr_msb_q) begin
                  count_d = {data_in, staged_q};
                  load_d  = 1'b1;
               end else begin
                  staged_d = data_in;
               end
            end
            default: ;
         endcase
         if (load_d) begin
            cs_d   = 1'b1;
            null_d = 1'b0;
         end
      end else if (rd_en) begin
         if (addr == COUNTER_ID) data_out_d = rd_data;
         else if (addr == ADDR_CTRL) data_out_d = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw_q       <= RW_LSB_MSB;
         mode_q     <= MODE_RESET;
         bcd_q      <= 1'b0;
         cs_q       <= 1'b0;
         null_q     <= 1'b1;
         load_q     <= 1'b0;
         wr_msb_q   <= 1'b0;
         count_q    <= '0;
         staged_q   <= '0;
         data_out_q <= '0;
      end else begin
         rw_q       <= rw_d;
         mode_q     <= mode_d;
         bcd_q      <= bcd_d;
         cs_q       <= cs_d;
         null_q     <= null_d;
         load_q     <= load_d;
         wr_msb_q   <= wr_msb_d;
         count_q    <= count_d;
         staged_q   <= staged_d;
         data_out_q <= data_out_d;
      end
   end

   count_read_latch u_read (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear_latch),
      .latch_cmd     (latch_cmd),
`ifdef COUNTER_READBACK_EN
      .status_cmd    (status_cmd),
      .status_in     (status_byte),
`endif
      .rd_strobe     (rd_strobe),
      .rw            (rw_q),
      .current_count (current_count),
      .rd_data       (rd_data)
   );

   assign data_out   = data_out_q;
   assign count_out  = count_q;
   assign count_load = load_q;
   assign cs_out     = cs_q;
   assign mode_out   = mode_q;
   assign bcd_out    = bcd_q;
   assign null_count = null_q;

endmodule

// File: tb/tb_counter_access_unit.sv
// Testbench for counter_access_unit (COUNTER_ID = 0).
// Directed scenarios with fixed expected values, then a randomized run
// compared against a behavioural model of the CPU-visible register rules.
// The read-back scenario is only built when COUNTER_READBACK_EN is defined.
module tb_counter_access_unit;

   localparam logic [1:0] ID = 2'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [1:0]  addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [15:0] count_out;
   logic        count_load;
   logic        cs_out;
   logic [2:0]  mode_out;
   logic        bcd_out;
   logic        null_count;
   logic [15:0] current_count;
   logic        out_in;

   int checks = 0;
   int errors = 0;
   int loads_seen = 0;

   // Model state
   logic [1:0]  m_rw;
   logic [2:0]  m_mode;
   logic        m_bcd, m_cs, m_null, m_load;
   logic [15:0] m_count;
   bit          m_have_lsb;
   logic [7:0]  m_staged;
   bit          m_latched;
   logic [15:0] m_latch;
   bit          m_rd_msb;
   logic [7:0]  m_status[$];
   logic [7:0]  m_data_out;

   always #5 clk = ~clk;

   counter_access_unit #(.COUNTER_ID(ID)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .addr          (addr),
      .data_in       (data_in),
      .data_out      (data_out),
      .count_out     (count_out),
      .count_load    (count_load),
      .cs_out        (cs_out),
      .mode_out      (mode_out),
      .bcd_out       (bcd_out),
      .null_count    (null_count),
      .current_count (current_count),
      .out_in        (out_in)
   );

   task automatic model_reset();
      m_rw = 2'd3; m_mode = 3'd1; m_bcd = 0; m_cs = 0; m_null = 1; m_load = 0;
      m_count = 0; m_have_lsb = 0; m_staged = 0; m_latched = 0; m_latch = 0;
      m_rd_msb = 0; m_status.delete(); m_data_out = 0;
   endtask

   task automatic model_complete(input logic [15:0] value);
      m_count = value; m_load = 1; m_cs = 1; m_null = 0;
   endtask

   task automatic model_write(input logic [1:0] a, input logic [7:0] d);
      logic [2:0] m;
      m_load = 0;
      if (a == 2'd3) begin
         if (d[7:6] == ID) begin
            if (d[5:4] == 2'd0) begin
               if (!m_latched) begin m_latch = current_count; m_latched = 1; end
            end else begin
               m = d[3:1];
               m_rw = d[5:4];
               m_mode = (m >= 3'd6) ? m - 3'd4 : m;
               m_bcd = d[0]; m_cs = 0; m_null = 1;
               m_have_lsb = 0; m_rd_msb = 0; m_latched = 0; m_status.delete();
            end
         end
`ifdef COUNTER_READBACK_EN
         else if (d[7:6] == 2'd3 && d[int'(ID) + 1]) begin
            if (!d[4] && m_status.size() == 0)
               m_status.push_back({out_in, m_null, m_rw, m_mode, m_bcd});
            if (!d[5] && !m_latched) begin m_latch = current_count; m_latched = 1; end
         end
`endif
      end else if (a == ID) begin
         if (m_rw == 2'd1) model_complete({8'h00, d});
         else if (m_rw == 2'd2) model_complete({d, 8'h00});
         else if (!m_have_lsb) begin m_staged = d; m_have_lsb = 1; end
         else begin model_complete(16'(d) * 16'd256 + 16'(m_staged)); m_have_lsb = 0; end
      end
   endtask

   task automatic model_read(input logic [1:0] a);
      logic [15:0] src;
      m_load = 0;
      if (a == ID) begin
         if (m_status.size() > 0) m_data_out = m_status.pop_front();
         else begin
            src = m_latched ? m_latch : current_count;
            if (m_rw == 2'd1) begin m_data_out = 8'(src % 256); m_latched = 0; end
            else if (m_rw == 2'd2) begin m_data_out = 8'(src / 256); m_latched = 0; end
            else begin
               m_data_out = m_rd_msb ? 8'(src / 256) : 8'(src % 256);
               if (m_rd_msb) m_latched = 0;
               m_rd_msb = !m_rd_msb;
            end
         end
      end else if (a == 2'd3) m_data_out = 8'h00;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; data_in = d; wr_en = 1'b1; rd_en = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      model_write(a, d);
      if (count_load === 1'b1) loads_seen++;
   endtask

   task automatic bus_read(input logic [1:0] a);
      @(negedge clk);
      addr = a; rd_en = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      rd_en = 1'b0;
      model_read(a);
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({count_out, count_load, cs_out, mode_out, bcd_out, null_count, data_out} !==
          {16'h0000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("[TB] FAIL reset_values: got count=%h load=%b cs=%b mode=%b bcd=%b null=%b dout=%h, expected 0000 0 0 001 0 1 00",
                  count_out, count_load, cs_out, mode_out, bcd_out, null_count, data_out);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_program_load();
      bus_write(2'd3, 8'h32);
      checks++;
      if ({cs_out, mode_out, null_count} !== {1'b0, 3'b001, 1'b1}) begin
         errors++;
         $display("[TB] FAIL program_ctrl: got cs=%b mode=%b null=%b, expected 0 001 1", cs_out, mode_out, null_count);
      end
      bus_write(ID, 8'h34);
      checks++;
      if (count_load !== 1'b0) begin
         errors++;
         $display("[TB] FAIL first_byte_no_load: got load=%b, expected 0", count_load);
      end
      bus_write(ID, 8'h12);
      checks++;
      if ({count_load, count_out, cs_out, null_count} !== {1'b1, 16'h1234, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL two_byte_load: got load=%b count=%h cs=%b null=%b, expected 1 1234 1 0",
                  count_load, count_out, cs_out, null_count);
      end
      @(negedge clk);
      m_load = 0;
      checks++;
      if (count_load !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_one_cycle: got load=%b, expected 0", count_load);
      end
      bus_write(2'd3, 8'h3C);
      checks++;
      if (mode_out !== 3'b010) begin
         errors++;
         $display("[TB] FAIL mode_alias: got mode=%b, expected 010", mode_out);
      end
   endtask

   task automatic test_single_byte();
      bus_write(2'd3, 8'h10);
      bus_write(ID, 8'hAB);
      checks++;
      if ({count_load, count_out} !== {1'b1, 16'h00AB}) begin
         errors++;
         $display("[TB] FAIL lsb_only: got load=%b count=%h, expected 1 00AB", count_load, count_out);
      end
      bus_write(2'd3, 8'h20);
      bus_write(ID, 8'hCD);
      checks++;
      if ({count_load, count_out} !== {1'b1, 16'hCD00}) begin
         errors++;
         $display("[TB] FAIL msb_only: got load=%b count=%h, expected 1 CD00", count_load, count_out);
      end
   endtask

   task automatic test_latch();
      bus_write(2'd3, 8'h30);
      current_count = 16'h5678;
      bus_write(2'd3, 8'h00);
      current_count = 16'h1111;
      bus_read(ID);
      checks++;
      if (data_out !== 8'h78) begin
         errors++; $display("[TB] FAIL latch_lsb: got %h, expected 78", data_out);
      end
      bus_read(ID);
      checks++;
      if (data_out !== 8'h56) begin
         errors++; $display("[TB] FAIL latch_msb: got %h, expected 56", data_out);
      end
      bus_read(ID);
      checks++;
      if (data_out !== 8'h11) begin
         errors++; $display("[TB] FAIL live_after_release: got %h, expected 11", data_out);
      end
      bus_read(ID);
   endtask

   task automatic test_double_latch();
      current_count = 16'h1234;
      bus_write(2'd3, 8'h00);
      current_count = 16'h5678;
      bus_write(2'd3, 8'h00);
      bus_read(ID);
      checks++;
      if (data_out !== 8'h34) begin
         errors++; $display("[TB] FAIL second_latch_ignored_lsb: got %h, expected 34", data_out);
      end
      bus_read(ID);
      checks++;
      if (data_out !== 8'h12) begin
         errors++; $display("[TB] FAIL second_latch_ignored_msb: got %h, expected 12", data_out);
      end
      bus_read(2'd3);
      checks++;
      if (data_out !== 8'h00) begin
         errors++; $display("[TB] FAIL ctrl_read_zero: got %h, expected 00", data_out);
      end
   endtask

   task automatic test_reprogram_and_reset();
      pulse_reset();
      loads_seen = 0;
      bus_write(ID, 8'h34);
      bus_write(2'd3, 8'h32);
      bus_write(ID, 8'h01);
      bus_write(ID, 8'h00);
      checks++;
      if (loads_seen != 1 || count_out !== 16'h0001) begin
         errors++;
         $display("[TB] FAIL reprogram_discard: got loads=%0d count=%h, expected 1 0001", loads_seen, count_out);
      end
      bus_write(ID, 8'h55);
      @(negedge clk);
      addr = ID; data_in = 8'hAA; wr_en = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({count_out, count_load, cs_out, mode_out, bcd_out, null_count, data_out} !==
          {16'h0000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("[TB] FAIL async_reset: got count=%h load=%b cs=%b mode=%b null=%b, expected 0000 0 0 001 1",
                  count_out, count_load, cs_out, mode_out, null_count);
      end
      @(negedge clk);
      checks++;
      if (count_load !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_no_pulse: got load=%b, expected 0", count_load);
      end
      wr_en = 1'b0; rst = 1'b0;
      model_reset();
      bus_write(ID, 8'h77);
      checks++;
      if (count_load !== 1'b0) begin
         errors++; $display("[TB] FAIL staged_dropped: got load=%b, expected 0", count_load);
      end
      bus_write(ID, 8'h66);
      checks++;
      if ({count_load, count_out} !== {1'b1, 16'h6677}) begin
         errors++; $display("[TB] FAIL after_reset_load: got load=%b count=%h, expected 1 6677", count_load, count_out);
      end
   endtask

   task automatic test_simultaneous();
      bus_write(2'd3, 8'h10);
      bus_read(2'd3);
      current_count = 16'h00FF;
      @(negedge clk);
      addr = ID; data_in = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      model_write(ID, 8'h5A);
      checks++;
      if ({data_out, count_load, count_out} !== {8'h00, 1'b1, 16'h005A}) begin
         errors++;
         $display("[TB] FAIL wr_rd_collision: got dout=%h load=%b count=%h, expected 00 1 005A",
                  data_out, count_load, count_out);
      end
   endtask

`ifdef COUNTER_READBACK_EN
   task automatic test_readback();
      bus_write(2'd3, 8'h32);
      bus_write(ID, 8'h34);
      bus_write(ID, 8'h12);
      out_in = 1'b1;
      current_count = 16'hBEEF;
      bus_write(2'd3, 8'hC2);
      current_count = 16'h0000;
      bus_read(ID);
      checks++;
      if (data_out !== 8'hB2) begin
         errors++; $display("[TB] FAIL readback_status: got %h, expected B2", data_out);
      end
      bus_read(ID);
      checks++;
      if (data_out !== 8'hEF) begin
         errors++; $display("[TB] FAIL readback_lsb: got %h, expected EF", data_out);
      end
      bus_read(ID);
      checks++;
      if (data_out !== 8'hBE) begin
         errors++; $display("[TB] FAIL readback_msb: got %h, expected BE", data_out);
      end
   endtask
`endif

   task automatic test_random();
      logic [7:0] d;
      for (int i = 0; i < 400; i++) begin
         current_count = 16'($urandom);
         out_in = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: bus_write(2'd3, {ID, 2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))});
            1: bus_write(2'd3, {ID, 2'b00, 4'($urandom)});
            2, 3: bus_write(ID, 8'($urandom));
            4, 5: bus_read(ID);
            6: bus_read(2'($urandom_range(1, 3)));
            default: begin
               d = 8'($urandom);
               if (d[7:6] == ID) d[7:6] = 2'($urandom_range(1, 3));
               if ($urandom_range(0, 1) == 1) bus_write(2'd3, d);
               else bus_write(2'($urandom_range(1, 2)), d);
            end
         endcase
         checks++;
         if ({count_out, count_load, cs_out, mode_out, bcd_out, null_count} !==
             {m_count, m_load, m_cs, m_mode, m_bcd, m_null}) begin
            errors++;
            $display("[TB] FAIL random_state[%0d]: got count=%h load=%b cs=%b mode=%b bcd=%b null=%b, expected %h %b %b %b %b %b",
                     i, count_out, count_load, cs_out, mode_out, bcd_out, null_count,
                     m_count, m_load, m_cs, m_mode, m_bcd, m_null);
         end
         checks++;
         if (data_out !== m_data_out) begin
            errors++;
            $display("[TB] FAIL random_read[%0d]: got %h, expected %h", i, data_out, m_data_out);
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; data_in = 8'h00;
      current_count = 16'h0000; out_in = 1'b0;
      model_reset();
      test_reset();
      test_program_load();
      test_single_byte();
      test_latch();
      test_double_latch();
      test_reprogram_and_reset();
      test_simultaneous();
`ifdef COUNTER_READBACK_EN
      test_readback();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
